// File: rtl/decryption_iter_if.sv
// Block-transfer bus for the iterative AES-128 decryptor.
// Carries both valid/ready handshakes: ciphertext into the core, plaintext out of it.
//   in_valid  producer -> core   d_in holds a ciphertext block
//   in_ready  core -> producer   core accepts d_in this cycle
//   d_in      producer -> core   128-bit ciphertext, byte 0 in [127:120], column-major
//   out_valid core -> consumer   d_out holds a plaintext block
//   out_ready consumer -> core   consumer takes d_out this cycle
//   d_out     core -> consumer   128-bit plaintext, same byte order as d_in
// slave is the core's view; master is the producer/consumer view.
interface decryption_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] d_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] d_out;

    modport slave (
        input  in_valid, d_in, out_ready,
        output in_ready, out_valid, d_out
    );

    modport master (
        output in_valid, d_in, out_ready,
        input  in_ready, out_valid, d_out
    );
endinterface

// File: rtl/decryption_iter.sv
// Iterative AES-128 inverse cipher: one round per clock over a single 128-bit
// state register, driven by an externally supplied 44-word key schedule.
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   key_schedule  expanded key, round key r = words 4r..4r+3 (word [31:24] = row 0)
//   bus           slave side of decryption_iter_if (ciphertext in, plaintext out)
//   busy          high while rounds are being computed
// State byte 4c+r (row r, column c) lives at bits [127-8*(4c+r) -: 8].
//
// inv_sbox: combinational AES inverse S-box, 8b -> 8b.
//   a_i  input byte
//   y_o  InvSubBytes(a_i)
module inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [7:0] TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y_o = TBL[a_i];
endmodule

// State table
//   state   | meaning
//   S_IDLE  | no block held, ready for ciphertext
//   S_ROUND | rounds in progress, rnd_q counts down to the final round
//   S_DONE  | plaintext held on d_out until the consumer takes it
module decryption_iter #(
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [0:43][31:0]   key_schedule,
    decryption_iter_if.slave    bus,
    output logic                busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [3:0]   rnd_q, rnd_d;

    logic         in_ready;
    logic         accept;
    logic [3:0]   rk_idx;
    logic [5:0]   kw;
    logic [127:0] rk;
    logic [127:0] isr, isb, ark, imc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r: output column c takes input column c-r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Multiplies by 09/0b/0d/0e are built from the xtime chain x2, x4, x8.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a  [4];
        logic [7:0]   x2 [4];
        logic [7:0]   x4 [4];
        logic [7:0]   x8 [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127-8*(4*c+r) -: 8];
                x2[r] = xt(a[r]);
                x4[r] = xt(x2[r]);
                x8[r] = xt(x4[r]);
            end
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] =
                    (x8[r] ^ x4[r] ^ x2[r]) ^
                    (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4]) ^
                    (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4]) ^
                    (x8[(r+3)%4] ^ a[(r+3)%4]);
            end
        end
        return o;
    endfunction

    // Outside ROUND the only key use is the initial whitening with the last round key.
    assign rk_idx = (fsm_q == S_ROUND) ? rnd_q : 4'(NR);
    assign kw     = {rk_idx, 2'b00};
    assign rk     = {key_schedule[kw], key_schedule[kw + 6'd1],
                     key_schedule[kw + 6'd2], key_schedule[kw + 6'd3]};

    assign isr = inv_shift_rows(blk_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_sbox (
            .a_i (isr[8*i +: 8]),
            .y_o (isb[8*i +: 8])
        );
    end

    assign ark = isb ^ rk;
    assign imc = inv_mix_columns(ark);

    assign in_ready = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q <= S_IDLE;
            blk_q <= '0;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            blk_q <= blk_d;
            rnd_q <= rnd_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        blk_d = blk_q;
        rnd_d = rnd_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    blk_d = bus.d_in ^ rk;
                    rnd_d = 4'(NR - 1);
                    fsm_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_q == 4'd0) begin
                    blk_d = ark;
                    fsm_d = S_DONE;
                end else begin
                    blk_d = imc;
                    rnd_d = rnd_q - 4'd1;
                end
            end
            S_DONE: begin
                // Hand-off and a new accept can share one edge.
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        blk_d = bus.d_in ^ rk;
                        rnd_d = 4'(NR - 1);
                        fsm_d = S_ROUND;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (fsm_q == S_DONE);
    assign bus.d_out     = blk_q;
    assign busy          = (fsm_q == S_ROUND);
endmodule

// File: tb/tb_decryption_iter.sv
// Directed and randomized bench for the iterative AES-128 decryptor.
module tb_decryption_iter;
    typedef logic [0:43][31:0] ks_t;

    logic       clk = 1'b0;
    logic       n_rst;
    ks_t        key_schedule;
    logic       busy;
    logic [7:0] sb [256];

    int n_tests = 0;
    int n_fail  = 0;

    decryption_iter_if bus ();

    decryption_iter dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .key_schedule (key_schedule),
        .bus          (bus),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic ks_t expand(input logic [127:0] key);
        ks_t        w;
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return w;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input ks_t w);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[4*c+r] = s[4*((c+r)%4)+r];
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++)
                        for (int r = 0; r < 4; r++)
                            s[4*c+r] = gf_mul(8'h02, t[4*c+r]) ^ gf_mul(8'h03, t[4*c+(r+1)%4]) ^
                                       t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                end else begin
                    for (int i = 0; i < 16; i++) s[i] = t[i];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid is seen, bounded so a dead core cannot hang the run.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] key1, ct1, pt1, key2, ct2, pt2, key, pt, ct;
        ks_t          ks1, ks2;
        int           lat, gap, bad, dup, stall;
        logic [7:0]   inv [256];
        logic [7:0]   x;

        key1 = 128'h000102030405060708090a0b0c0d0e0f;
        ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt1  = 128'h00112233445566778899aabbccddeeff;
        key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
        pt2  = 128'h3243f6a8885a308d313198a2e0370734;

        // Forward S-box from its definition: GF(2^8) inverse then affine map.
        for (int a = 0; a < 256; a++) inv[a] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv[a] = 8'(b);
        for (int a = 0; a < 256; a++) begin
            x = inv[a];
            sb[a] = x ^ ((x << 1) | (x >> 7)) ^ ((x << 2) | (x >> 6)) ^
                    ((x << 3) | (x >> 5)) ^ ((x << 4) | (x >> 4)) ^ 8'h63;
        end
        ks1 = expand(key1);
        ks2 = expand(key2);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.d_in      = '0;
        key_schedule  = ks1;
        n_rst         = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_d_out", bus.d_out, 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        #10 n_rst = 1'b1;
        step();

        // Vector 1 with latency measurement.
        bus.d_in     = ct1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("v1_busy", 128'(busy), 128'd1);
        chk("v1_in_ready_round", 128'(bus.in_ready), 128'd0);
        wait_out(lat);
        chk("v1_latency", 128'(lat), 128'd10);
        chk("v1_d_out", bus.d_out, pt1);

        // Consumer stall in DONE.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.d_out !== pt1 || bus.in_ready !== 1'b0) bad++;
        end
        chk("stall_stable", 128'(bad), 128'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", 128'(bus.in_ready), 128'd1);
        step();
        bus.out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.out_valid !== 1'b0) bad++;
            step();
        end
        chk("single_transfer", 128'(bad), 128'd0);
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // Vector 2.
        key_schedule = ks2;
        bus.d_in     = ct2;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("v2_latency", 128'(lat), 128'd10);
        chk("v2_d_out", bus.d_out, pt2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("v2_handoff", 128'(bus.out_valid), 128'd0);

        // Back-to-back: second block accepted on the first hand-off edge.
        key_schedule  = ks1;
        bus.d_in      = ct1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.d_in = ct2;
        wait_out(lat);
        chk("b2b_first_d_out", bus.d_out, pt1);
        chk("b2b_in_ready_done", 128'(bus.in_ready), 128'd1);
        key_schedule = ks2;
        step();
        bus.in_valid = 1'b0;
        chk("b2b_busy_after_handoff", 128'(busy), 128'd1);
        wait_out(gap);
        chk("b2b_gap", 128'(gap + 1), 128'd11);
        chk("b2b_second_d_out", bus.d_out, pt2);
        step();
        bus.out_ready = 1'b0;
        chk("b2b_drain", 128'(bus.out_valid), 128'd0);

        // Reset mid-block at rnd=5.
        bus.d_in     = ct1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("midrst_busy_before", 128'(busy), 128'd1);
        n_rst = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_d_out", bus.d_out, 128'd0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_busy", 128'(busy), 128'd0);
        #1 n_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid !== 1'b0) bad++;
        end
        chk("midrst_no_output", 128'(bad), 128'd0);
        bus.d_in     = ct2;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("postrst_latency", 128'(lat), 128'd10);
        chk("postrst_d_out", bus.d_out, pt2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Random keys/plaintexts through the encryption model, random consumer stalls.
        dup = 0;
        for (int n = 0; n < 1000; n++) begin
            key          = {$urandom, $urandom, $urandom, $urandom};
            pt           = {$urandom, $urandom, $urandom, $urandom};
            key_schedule = expand(key);
            ct           = encrypt(pt, key_schedule);
            bus.d_in     = ct;
            bus.in_valid = 1'b1;
            if (bus.in_ready !== 1'b1) dup++;
            step();
            bus.in_valid = 1'b0;
            wait_out(lat);
            if (lat != 10) dup++;
            stall = $urandom_range(0, 3);
            repeat (stall) step();
            chk("rand_d_out", bus.d_out, pt);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            if (bus.out_valid !== 1'b0) dup++;
        end
        chk("rand_flow", 128'(dup), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
